// File: rtl/alu_result_tx.sv
// Serial 8N1-style transmitter for the ALU result word: latches dato_in on tx_start
// and shifts out start bit, longDS data bits LSB-first, and a stop bit on tx.
module alu_result_tx #(
  parameter int longDS       = 8,
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_start,
  input  logic [longDS-1:0] dato_in,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (longDS > 0) ? $clog2(longDS + 1) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(longDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t              r_state;
  logic [longDS-1:0]   r_shift;
  logic [BAUD_W-1:0]   r_baud;
  logic [BIT_W-1:0]    r_bit;
  logic                r_tx;
  logic                r_busy;
  logic                r_done;

  logic                w_baud_end;
  logic [longDS-1:0]   w_shift_next;

  assign w_baud_end   = (r_baud == BAUD_LAST);
  assign w_shift_next = r_shift >> 1;

  // tx is registered and always updated together with the state, so the line
  // level for the next bit is ready on the same edge that changes state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_baud  <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          if (tx_start) begin
            r_shift <= dato_in;
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_START;
          end
        end

        S_START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        S_DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit == BIT_LAST) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_shift <= w_shift_next;
              r_tx    <= w_shift_next[0];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        S_STOP: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx      = r_tx;
  assign tx_busy = r_busy;
  assign tx_done = r_done;

endmodule

// File: tb/tb_alu_result_tx.sv
// Directed bench for alu_result_tx (CLKS_PER_BIT=4, longDS=8); frames are decoded
// by a sampling receiver model and compared against hand-built bit patterns.
module tb_alu_result_tx;

  localparam int CPB = 4;
  localparam int DW  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          tx_start = 1'b0;
  logic [DW-1:0] dato_in = '0;
  logic          tx;
  logic          tx_busy;
  logic          tx_done;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  alu_result_tx #(
    .longDS      (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_start(tx_start),
    .dato_in (dato_in),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  // Pulse tx_start for one edge; returns at the sample point of the first START cycle.
  task automatic start_frame(input logic [DW-1:0] d);
    tx_start = 1'b1;
    dato_in  = d;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Receiver model: samples one full frame (10 bits x CPB cycles) from the
  // current negedge and returns at the sample point right after the frame.
  task automatic rx_frame(output logic [9:0] bits, output int busy_cnt,
                          output int glitches, output int done_mid,
                          output logic done_end, output logic busy_end);
    bits = '0;
    busy_cnt = 0;
    glitches = 0;
    done_mid = 0;
    for (int b = 0; b < DW + 2; b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (c == 0) bits[b] = tx;
        else if (tx !== bits[b]) glitches++;
        if (tx_busy === 1'b1) busy_cnt++;
        if (tx_done !== 1'b0) done_mid++;
        @(negedge clk);
      end
    end
    done_end = tx_done;
    busy_end = tx_busy;
    $display("rx frame bits=%b data=%h busy_cycles=%0d", bits, bits[8:1], busy_cnt);
  endtask

  task automatic test_reset();
    int bad;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx); else passes++;
    checks++; if (tx_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", tx_busy); else passes++;
    checks++; if (tx_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", tx_done); else passes++;
    reset = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL idle_quiet: got %0d active cycles expected 0", bad); else passes++;
    start_frame(8'hF0);
    repeat (6) @(negedge clk);
    checks++; if (tx_busy !== 1'b1) $display("FAIL midframe_busy: got %b expected 1", tx_busy); else passes++;
    #2 reset = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) $display("FAIL async_reset_tx: got %b expected 1", tx); else passes++;
    checks++; if (tx_busy !== 1'b0) $display("FAIL async_reset_busy: got %b expected 0", tx_busy); else passes++;
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL post_reset_quiet: got %0d active cycles expected 0", bad); else passes++;
    $display("reset test transaction complete");
  endtask

  task automatic test_single_frame();
    logic [9:0] bits;
    int busy_cnt, glitches, done_mid;
    logic done_end, busy_end;
    start_frame(8'hA5);
    checks++; if (tx !== 1'b0 || tx_busy !== 1'b1) $display("FAIL latency: got tx=%b busy=%b expected tx=0 busy=1", tx, tx_busy); else passes++;
    rx_frame(bits, busy_cnt, glitches, done_mid, done_end, busy_end);
    checks++; if (bits !== 10'b1101001010) $display("FAIL a5_frame: got %b expected 1101001010", bits); else passes++;
    checks++; if (busy_cnt !== 40) $display("FAIL a5_busy_len: got %0d expected 40", busy_cnt); else passes++;
    checks++; if (glitches !== 0) $display("FAIL a5_bit_hold: got %0d glitches expected 0", glitches); else passes++;
    checks++; if (done_mid !== 0) $display("FAIL a5_done_early: got %0d expected 0", done_mid); else passes++;
    checks++; if (done_end !== 1'b1 || busy_end !== 1'b0) $display("FAIL a5_done_k41: got done=%b busy=%b expected done=1 busy=0", done_end, busy_end); else passes++;
    @(negedge clk);
    checks++; if (tx_done !== 1'b0) $display("FAIL a5_done_width: got %b expected 0", tx_done); else passes++;
  endtask

  task automatic test_ignore_busy();
    logic [9:0] bits;
    int busy_cnt, glitches, done_mid, extra;
    logic done_end, busy_end;
    start_frame(8'h3C);
    fork
      rx_frame(bits, busy_cnt, glitches, done_mid, done_end, busy_end);
      begin
        repeat (9) @(negedge clk);
        tx_start = 1'b1;
        dato_in  = 8'hFF;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    checks++; if (bits !== 10'b1001111000) $display("FAIL ignore_frame: got %b expected 1001111000", bits); else passes++;
    checks++; if (glitches !== 0) $display("FAIL ignore_bit_hold: got %0d glitches expected 0", glitches); else passes++;
    checks++; if (done_end !== 1'b1) $display("FAIL ignore_done: got %b expected 1", done_end); else passes++;
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_done !== 1'b0 || tx_busy !== 1'b0 || tx !== 1'b1) extra++;
    end
    checks++; if (extra !== 0) $display("FAIL ignore_no_queue: got %0d active cycles expected 0", extra); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [9:0] bits;
    int busy_cnt, glitches, done_mid;
    logic done_end, busy_end;
    tx_start = 1'b1;
    dato_in  = 8'h01;
    @(negedge clk);
    dato_in  = 8'h80;
    rx_frame(bits, busy_cnt, glitches, done_mid, done_end, busy_end);
    checks++; if (bits !== 10'b1000000010) $display("FAIL b2b_frame1: got %b expected 1000000010", bits); else passes++;
    checks++; if (done_end !== 1'b1 || tx !== 1'b1) $display("FAIL b2b_gap: got done=%b tx=%b expected done=1 tx=1", done_end, tx); else passes++;
    @(negedge clk);
    tx_start = 1'b0;
    checks++; if (tx !== 1'b0 || tx_busy !== 1'b1) $display("FAIL b2b_restart: got tx=%b busy=%b expected tx=0 busy=1", tx, tx_busy); else passes++;
    rx_frame(bits, busy_cnt, glitches, done_mid, done_end, busy_end);
    checks++; if (bits !== 10'b1100000000) $display("FAIL b2b_frame2: got %b expected 1100000000", bits); else passes++;
    checks++; if (busy_cnt !== 40 || done_end !== 1'b1) $display("FAIL b2b_frame2_len: got busy=%0d done=%b expected 40 1", busy_cnt, done_end); else passes++;
    @(negedge clk);
  endtask

  task automatic test_abort();
    logic [9:0] bits;
    int busy_cnt, glitches, done_mid, bad;
    logic done_end, busy_end;
    start_frame(8'h00);
    repeat (17) @(negedge clk);
    checks++; if (tx !== 1'b0) $display("FAIL abort_bit3_level: got %b expected 0", tx); else passes++;
    #2 reset = 1'b0;
    #1;
    checks++; if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) $display("FAIL abort_outputs: got tx=%b busy=%b done=%b expected 1 0 0", tx, tx_busy, tx_done); else passes++;
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (tx_done !== 1'b0 || tx !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL abort_no_done: got %0d active cycles expected 0", bad); else passes++;
    start_frame(8'h55);
    rx_frame(bits, busy_cnt, glitches, done_mid, done_end, busy_end);
    checks++; if (bits !== 10'b1010101010) $display("FAIL abort_resend_55: got %b expected 1010101010", bits); else passes++;
    checks++; if (busy_cnt !== 40 || glitches !== 0 || done_end !== 1'b1) $display("FAIL abort_resend_timing: got busy=%0d glitches=%0d done=%b expected 40 0 1", busy_cnt, glitches, done_end); else passes++;
  endtask

  task automatic test_edge_data();
    logic [9:0] bits;
    int busy_cnt, glitches, done_mid;
    logic done_end, busy_end;
    start_frame(8'h00);
    rx_frame(bits, busy_cnt, glitches, done_mid, done_end, busy_end);
    checks++; if (bits !== 10'b1000000000) $display("FAIL edge_00: got %b expected 1000000000", bits); else passes++;
    checks++; if (glitches !== 0 || done_end !== 1'b1) $display("FAIL edge_00_timing: got glitches=%0d done=%b expected 0 1", glitches, done_end); else passes++;
    start_frame(8'hFF);
    rx_frame(bits, busy_cnt, glitches, done_mid, done_end, busy_end);
    checks++; if (bits !== 10'b1111111110) $display("FAIL edge_ff: got %b expected 1111111110", bits); else passes++;
    checks++; if (busy_cnt !== 40 || done_end !== 1'b1) $display("FAIL edge_ff_timing: got busy=%0d done=%b expected 40 1", busy_cnt, done_end); else passes++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_ignore_busy();
    test_back_to_back();
    test_abort();
    test_edge_data();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
